// File: rtl/demuxer.sv
// rtl/demuxer.sv - two-channel tag demultiplexer with per-channel FIFOs
//
// Purpose:
//   Routes each tagged input word into the FIFO selected by in_channel. Each
//   channel FIFO (DEPTH entries) is drained independently through registered
//   head-word / available outputs, so a word accepted at edge k is visible
//   right after edge k.
//
// Optional feature macro: DEMUXER_DROP_EN
//   undefined : a full tagged channel back-pressures the input (head-of-line).
//   defined   : input is always ready; a word for a full channel is discarded
//               and out_dropped pulses for one cycle.
//
// Ports:
//   clk                   system clock, rising edge
//   reset                 asynchronous, active-low reset
//   in_data               input word
//   in_channel            destination tag (0 -> channel 0, 1 -> channel 1)
//   in_data_available     producer presents a valid word
//   in_data_ready         demuxer can accept the presented word (combinational)
//   out_data_N            head word of channel N (N = 0, 1)
//   out_data_N_available  channel N FIFO not empty
//   out_data_N_ready      receiver N accepts the head word
//   out_dropped           one-cycle pulse per discarded word (DEMUXER_DROP_EN only)
module demuxer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_channel,
  input  logic                  in_data_available,
  output logic                  in_data_ready,
  output logic [DATA_WIDTH-1:0] out_data_0,
  output logic                  out_data_0_available,
  input  logic                  out_data_0_ready,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic                  out_data_1_available,
  input  logic                  out_data_1_ready
`ifdef DEMUXER_DROP_EN
  ,
  output logic                  out_dropped
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [1:0][PW-1:0]         wp_q, wp_d;
  logic [1:0][PW-1:0]         rp_q, rp_d;
  logic [DATA_WIDTH-1:0]      mem_q [2][DEPTH];
  logic [DATA_WIDTH-1:0]      mem_d [2][DEPTH];
  logic [1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]                 out_avail_q, out_avail_d;
  logic [1:0]                 full;
  logic [1:0]                 push;
  logic [1:0]                 pop;
  logic [1:0]                 out_ready;
  logic                       accept;

  assign out_ready = {out_data_1_ready, out_data_0_ready};

  always_comb begin
    full = '0;
    for (int c = 0; c < 2; c++) begin
      full[c] = (wp_q[c][AW] != rp_q[c][AW]) &&
                (wp_q[c][AW-1:0] == rp_q[c][AW-1:0]);
    end
  end

`ifdef DEMUXER_DROP_EN
  logic out_dropped_q, out_dropped_d;

  assign in_data_ready = reset;
  assign out_dropped   = out_dropped_q;
`else
  // Head-of-line: only the tagged channel's fullness matters, even when idle.
  assign in_data_ready = reset & ~full[in_channel];
`endif

  assign accept = in_data_available & in_data_ready;

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    mem_d       = mem_q;
    out_data_d  = out_data_q;
    out_avail_d = '0;
    push        = '0;
    // Registered available equals "not empty", so it qualifies the pop directly.
    pop         = out_avail_q & out_ready;
    // Fullness is taken before any same-cycle pop: a full FIFO never takes a push.
    push[in_channel] = accept & ~full[in_channel];
`ifdef DEMUXER_DROP_EN
    out_dropped_d = accept & full[in_channel];
`endif

    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_d[c][wp_q[c][AW-1:0]] = in_data;
        wp_d[c]                   = wp_q[c] + PW'(1);
      end
      if (pop[c]) begin
        rp_d[c] = rp_q[c] + PW'(1);
      end
      // Output registers load the post-edge head so latency is one cycle;
      // the data word simply holds when the FIFO goes empty.
      out_avail_d[c] = (wp_d[c] != rp_d[c]);
      if (out_avail_d[c]) begin
        out_data_d[c] = mem_d[c][rp_d[c][AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q          <= '0;
      rp_q          <= '0;
      out_data_q    <= '0;
      out_avail_q   <= '0;
`ifdef DEMUXER_DROP_EN
      out_dropped_q <= 1'b0;
`endif
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      out_data_q    <= out_data_d;
      out_avail_q   <= out_avail_d;
`ifdef DEMUXER_DROP_EN
      out_dropped_q <= out_dropped_d;
`endif
    end
  end

  // Storage needs no reset: pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_data_0           = out_data_q[0];
  assign out_data_1           = out_data_q[1];
  assign out_data_0_available = out_avail_q[0];
  assign out_data_1_available = out_avail_q[1];

endmodule

// File: tb/tb_demuxer.sv
// tb/tb_demuxer.sv - self-checking bench for demuxer
module tb_demuxer;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
`ifdef DEMUXER_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_channel;
  logic          in_data_available;
  logic          in_data_ready;
  logic [DW-1:0] out_data_0;
  logic          out_data_0_available;
  logic          out_data_0_ready;
  logic [DW-1:0] out_data_1;
  logic          out_data_1_available;
  logic          out_data_1_ready;
`ifdef DEMUXER_DROP_EN
  logic          out_dropped;
`endif

  demuxer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_data              (in_data),
    .in_channel           (in_channel),
    .in_data_available    (in_data_available),
    .in_data_ready        (in_data_ready),
    .out_data_0           (out_data_0),
    .out_data_0_available (out_data_0_available),
    .out_data_0_ready     (out_data_0_ready),
    .out_data_1           (out_data_1),
    .out_data_1_available (out_data_1_available),
    .out_data_1_ready     (out_data_1_ready)
`ifdef DEMUXER_DROP_EN
    ,
    .out_dropped          (out_dropped)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          avail;
    logic          ch;
    logic [DW-1:0] data;
    logic          r0;
    logic          r1;
    logic          exp_rdy;
    logic          exp_av0;
    logic [DW-1:0] exp_d0;
    logic          exp_av1;
    logic [DW-1:0] exp_d1;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic ch, input logic [DW-1:0] d,
                              input logic r0, input logic r1, input logic er,
                              input logic ea0, input logic [DW-1:0] ed0,
                              input logic ea1, input logic [DW-1:0] ed1);
    vec_t v;
    v.avail = av; v.ch = ch; v.data = d; v.r0 = r0; v.r1 = r1;
    v.exp_rdy = er; v.exp_av0 = ea0; v.exp_d0 = ed0; v.exp_av1 = ea1; v.exp_d1 = ed1;
    return v;
  endfunction

  // Reference model: one plain queue per channel, capacity DEPTH.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  task automatic model_cycle(input string tag, input logic av, input logic ch,
                             input logic [DW-1:0] d, input logic r0, input logic r1);
    logic fullc;
    logic exp_rdy;
    logic take;
    in_data_available = av;
    in_channel        = ch;
    in_data           = d;
    out_data_0_ready  = r0;
    out_data_1_ready  = r1;
    fullc   = ((ch ? q1.size() : q0.size()) >= DEPTH);
    exp_rdy = DROP ? 1'b1 : !fullc;
    take    = av && !fullc;
    #1;
    check({tag, "_ready"}, in_data_ready, exp_rdy);
    @(posedge clk);
    #1;
    if (r0 && q0.size() > 0) void'(q0.pop_front());
    if (r1 && q1.size() > 0) void'(q1.pop_front());
    if (take) begin
      if (ch) q1.push_back(d);
      else    q0.push_back(d);
    end
    check({tag, "_av0"}, out_data_0_available, q0.size() != 0);
    check({tag, "_av1"}, out_data_1_available, q1.size() != 0);
    if (q0.size() != 0) check({tag, "_d0"}, out_data_0, q0[0]);
    if (q1.size() != 0) check({tag, "_d1"}, out_data_1, q1[0]);
`ifdef DEMUXER_DROP_EN
    check({tag, "_drop"}, out_dropped, av && fullc);
`endif
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = mk(1, 0, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 8'h00);
    vecs[1]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00);
    vecs[2]  = mk(1, 0, 8'h01, 0, 0, 1, 1, 8'h01, 0, 8'h00);
    vecs[3]  = mk(1, 0, 8'h02, 0, 0, 1, 1, 8'h01, 0, 8'h00);
    vecs[4]  = mk(1, 0, 8'h03, 0, 0, 0, 1, 8'h01, 0, 8'h00);
    vecs[5]  = mk(0, 1, 8'h00, 0, 0, 1, 1, 8'h01, 0, 8'h00);
    vecs[6]  = mk(1, 0, 8'h03, 1, 0, 0, 1, 8'h02, 0, 8'h00);
    vecs[7]  = mk(1, 0, 8'h03, 1, 0, 1, 1, 8'h03, 0, 8'h00);
    vecs[8]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00);
    vecs[9]  = mk(1, 1, 8'h20, 0, 0, 1, 0, 8'h00, 1, 8'h20);
    vecs[10] = mk(1, 1, 8'h21, 0, 0, 1, 0, 8'h00, 1, 8'h20);
    vecs[11] = mk(1, 1, 8'h55, 0, 0, 0, 0, 8'h00, 1, 8'h20);
    vecs[12] = mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 8'h20);
    vecs[13] = mk(0, 1, 8'h00, 0, 1, 0, 0, 8'h00, 1, 8'h21);
    vecs[14] = mk(0, 1, 8'h00, 0, 1, 1, 0, 8'h00, 0, 8'h00);

    reset = 1'b0;
    in_data = '0; in_channel = 1'b0; in_data_available = 1'b0;
    out_data_0_ready = 1'b0; out_data_1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_av0", out_data_0_available, 1'b0);
    check("rst_av1", out_data_1_available, 1'b0);
    check("rst_d0", out_data_0, 8'h00);
    check("rst_d1", out_data_1, 8'h00);
`ifdef DEMUXER_DROP_EN
    check("rst_drop", out_dropped, 1'b0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      in_data_available = vecs[i].avail;
      in_channel        = vecs[i].ch;
      in_data           = vecs[i].data;
      out_data_0_ready  = vecs[i].r0;
      out_data_1_ready  = vecs[i].r1;
      #1;
      check($sformatf("vec%0d_ready", i), in_data_ready, DROP ? 1'b1 : vecs[i].exp_rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_av0", i), out_data_0_available, vecs[i].exp_av0);
      check($sformatf("vec%0d_av1", i), out_data_1_available, vecs[i].exp_av1);
      if (vecs[i].exp_av0) check($sformatf("vec%0d_d0", i), out_data_0, vecs[i].exp_d0);
      if (vecs[i].exp_av1) check($sformatf("vec%0d_d1", i), out_data_1, vecs[i].exp_d1);
`ifdef DEMUXER_DROP_EN
      check($sformatf("vec%0d_drop", i), out_dropped, vecs[i].avail && !vecs[i].exp_rdy);
`endif
    end

    // Interleaved pushes with both receivers always ready.
    for (int i = 0; i < 8; i++) begin
      model_cycle("ilv", 1'b1, 1'(i % 2), DW'(8'h10 + i), 1'b1, 1'b1);
    end
    repeat (2) model_cycle("ilv_drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Random traffic with sparse receivers so both FIFOs fill and stall.
    for (int i = 0; i < 400; i++) begin
      model_cycle("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  DW'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 2) == 0));
    end

    // Mid-stream asynchronous reset with both FIFOs holding data.
    model_cycle("pre_rst", 1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
    model_cycle("pre_rst", 1'b1, 1'b1, 8'h31, 1'b0, 1'b0);
    model_cycle("pre_rst", 1'b1, 1'b0, 8'h32, 1'b0, 1'b0);
    in_data_available = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_av0", out_data_0_available, 1'b0);
    check("mid_rst_av1", out_data_1_available, 1'b0);
    check("mid_rst_d0", out_data_0, 8'h00);
    check("mid_rst_d1", out_data_1, 8'h00);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_cycle("post_rst", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    model_cycle("post_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
